attractor_scan_ctrl: RTL and testbench



---
 rtl/attractor_scan_ctrl.sv | 118 +++++++++++
 tb/tb_attractor_scan_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/attractor_scan_ctrl.sv
// attractor_scan_ctrl
//   Sweeps every N-bit initial state of an external boolean network and
//   classifies each trajectory as fixed point (period 1), 2-cycle (period 2)
//   or timeout (period 0). Each outcome is one record on a valid/ready stream.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        begin a sweep (only honoured in IDLE)
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last record is accepted
//   net_state    state register presented to the external update logic
//   net_next     f(net_state) returned by the external network
//   res_valid    record valid; res_* held until accepted
//   res_ready    consumer accepts the record
//   res_init     initial state of the record
//   res_period   1 = fixed point, 2 = 2-cycle, 0 = timeout
//   res_steps    network updates taken to detection / timeout
//   res_state    net_next at the detect (or timeout) cycle
module attractor_scan_ctrl #(
  parameter int N         = 8,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      net_state,
  input  logic [N-1:0]      net_next,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_init,
  output logic [1:0]        res_period,
  output logic [STEP_W-1:0] res_steps,
  output logic [N-1:0]      res_state
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, REPORT, FIN} state_t;

  state_t            state;
  logic [N-1:0]      init_cnt;
  logic [N-1:0]      hist;      // s_{k-1}
  logic              hist_vld;  // hist is meaningful only from k>=1
  logic [STEP_W-1:0] k;

  logic fix_hit, cyc_hit, lim_hit;

  assign fix_hit = (net_next == net_state);
  assign cyc_hit = hist_vld && (net_next == hist);
  assign lim_hit = (k == STEP_W'(MAX_STEPS - 1));

  // Status outputs are pure decodes of the state register, so they change
  // only on clock edges and carry no combinational path from the inputs.
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign res_valid = (state == REPORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      init_cnt   <= '0;
      hist       <= '0;
      hist_vld   <= 1'b0;
      k          <= '0;
      net_state  <= '0;
      res_init   <= '0;
      res_period <= 2'd0;
      res_steps  <= '0;
      res_state  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            init_cnt <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          net_state <= init_cnt;
          hist_vld  <= 1'b0;
          k         <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (fix_hit || cyc_hit || lim_hit) begin
            // A detection on the final allowed step wins over timeout.
            res_period <= fix_hit ? 2'd1 : (cyc_hit ? 2'd2 : 2'd0);
            res_steps  <= k + STEP_W'(1);
            res_state  <= net_next;
            res_init   <= init_cnt;
            state      <= REPORT;
          end else begin
            hist      <= net_state;
            hist_vld  <= 1'b1;
            net_state <= net_next;
            k         <= k + STEP_W'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            if (init_cnt == {N{1'b1}}) begin
              state <= FIN;
            end else begin
              init_cnt <= init_cnt + N'(1);
              state    <= LOAD;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attractor_scan_ctrl.sv
// Self-checking bench for attractor_scan_ctrl. A behavioural model walks each
// trajectory with plain iteration and predicts every record, the cycle on
// which it appears, and the state register value along the way.
module tb_attractor_scan_ctrl;
  localparam int N = 8, MAX_STEPS = 64, STEP_W = 8;
  localparam int NREC = 1 << N;

  logic clk = 0, rst = 1, start = 0, res_ready = 0;
  logic busy, done, res_valid;
  logic [N-1:0] net_state, net_next, res_init, res_state;
  logic [1:0] res_period;
  logic [STEP_W-1:0] res_steps;

  attractor_scan_ctrl #(.N(N), .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .net_state(net_state), .net_next(net_next),
    .res_valid(res_valid), .res_ready(res_ready), .res_init(res_init),
    .res_period(res_period), .res_steps(res_steps), .res_state(res_state));

  always #5 clk = ~clk;

  // 0 identity, 1 inverter, 2 increment, 3 random table, 4 climb to fixed 63
  int mode = 0;
  logic [N-1:0] lut [NREC];

  always_comb begin
    net_next = net_state;
    case (mode)
      1: net_next = ~net_state;
      2: net_next = net_state + 8'd1;
      3: net_next = lut[net_state];
      4: net_next = (net_state < 8'd63) ? net_state + 8'd1 : net_state;
      default: net_next = net_state;
    endcase
  end

  function automatic logic [N-1:0] f(input logic [N-1:0] s);
    case (mode)
      1: return ~s;
      2: return s + 8'd1;
      3: return lut[s];
      4: return (s < 8'd63) ? s + 8'd1 : s;
      default: return s;
    endcase
  endfunction

  function automatic logic [N-1:0] s_at(input logic [N-1:0] init, input int j);
    logic [N-1:0] s;
    s = init;
    for (int i = 0; i < j; i++) s = f(s);
    return s;
  endfunction

  // Walk the trajectory: fixed point beats 2-cycle beats running out of steps.
  function automatic void model(input logic [N-1:0] init, output int per,
                                output int steps, output logic [N-1:0] fs);
    logic [N-1:0] cur, prev, nx;
    bit pv;
    cur = init; prev = '0; pv = 0; per = 0; steps = MAX_STEPS; fs = '0;
    for (int j = 0; j < MAX_STEPS; j++) begin
      nx = f(cur);
      fs = nx;
      if (nx == cur) begin per = 1; steps = j + 1; return; end
      if (pv && nx == prev) begin per = 2; steps = j + 1; return; end
      prev = cur; pv = 1; cur = nx;
    end
  endfunction

  int checks = 0, errors = 0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep bookkeeping shared by tick()/sweep().
  int rec, cyc_since, pct, hold_init, hold_left;
  bit in_sweep = 0, last_flag = 0, start_noise = 0;

  // One cycle at the falling edge: check outputs, drive inputs, advance.
  task automatic tick();
    int per, steps, c;
    logic [N-1:0] fs;
    bit exp_valid, hs;
    cyc_since++;
    c = cyc_since;
    exp_valid = 0;
    per = 0; steps = 0; fs = '0;
    if (in_sweep && rec < NREC) begin
      model(rec[N-1:0], per, steps, fs);
      exp_valid = (c >= steps + 2);
      if (c >= 2)
        chk(net_state, s_at(rec[N-1:0], (c - 2 < steps - 1) ? c - 2 : steps - 1), "net_state");
    end
    chk(busy, in_sweep, "busy");
    chk(done, last_flag, "done");
    chk(res_valid, exp_valid, "res_valid");
    if (exp_valid) begin
      chk(res_init, rec, "res_init");
      chk(res_period, per, "res_period");
      chk(res_steps, steps, "res_steps");
      chk(res_state, fs, "res_state");
    end
    if (last_flag) begin in_sweep = 0; last_flag = 0; end
    // drive
    if (res_valid && int'(res_init) == hold_init && hold_left > 0) begin
      res_ready = 0; hold_left--;
    end else begin
      res_ready = ($urandom_range(99) < pct);
    end
    start = in_sweep && start_noise && ($urandom_range(3) == 0);
    hs = res_valid && res_ready;
    if (hs) begin
      rec++; cyc_since = 0;
      if (rec == NREC) last_flag = 1;
    end
    @(negedge clk);
  endtask

  task automatic begin_sweep(input int m, input int p, input int hi, input bit noise);
    mode = m; pct = p; hold_init = hi; hold_left = 10; start_noise = noise;
    rec = 0; cyc_since = 0; in_sweep = 1; last_flag = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic sweep(input int m, input int p, input int hi, input bit noise);
    begin_sweep(m, p, hi, noise);
    for (int i = 0; i < 40000 && in_sweep; i++) tick();
    chk(32'(in_sweep), 0, "sweep_timeout");
    in_sweep = 0; last_flag = 0;
    repeat (3) tick();  // idle: busy/done/res_valid must stay low
  endtask

  initial begin
    for (int i = 0; i < NREC; i++)
      lut[i] = ($urandom_range(3) == 0) ? 8'(i) : 8'($urandom_range(255));

    // Reset state
    repeat (2) @(negedge clk);
    chk(busy, 0, "rst_busy");
    chk(done, 0, "rst_done");
    chk(res_valid, 0, "rst_valid");
    chk(net_state, 0, "rst_net_state");
    chk(res_init, 0, "rst_res_init");
    chk(res_period, 0, "rst_res_period");
    chk(res_steps, 0, "rst_res_steps");
    chk(res_state, 0, "rst_res_state");
    rst = 0;
    pct = 100; hold_init = -1;
    repeat (2) tick();

    sweep(0, 100, -1, 0);  // identity: period 1, 3 cycles per record
    sweep(1, 100, 5, 1);   // inverter, 10-cycle stall on 0x05, stray starts
    sweep(2, 100, -1, 0);  // increment: timeout after 64 steps
    sweep(3, 70, -1, 1);   // random table, random backpressure
    sweep(4, 100, -1, 1);  // init 0 hits its fixed point exactly at step 64

    // Abort during init 0x10, step 5 of the increment network
    begin_sweep(2, 100, -1, 0);
    for (int i = 0; i < 5000 && !(rec == 16 && cyc_since == 6); i++) tick();
    chk(net_state, 8'h15, "abort_net_state");
    rst = 1;
    @(negedge clk);
    rst = 0;
    in_sweep = 0; last_flag = 0;
    chk(busy, 0, "abort_busy");
    chk(res_valid, 0, "abort_valid");
    chk(done, 0, "abort_done");
    chk(net_state, 0, "abort_net_zero");
    repeat (5) tick();     // no done must follow the abort
    sweep(0, 50, -1, 0);   // fresh sweep restarts at res_init 0

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
